// File: rtl/adc_frame_ctrl.sv
// Frame master for a 16-SCLK serial 12-bit ADC: CS/SCLK/DIN generation at a fixed sample rate.
// Optional build macro ADC_SCAN_EN: auto-scan channels 0..NUM_CH-1 instead of using i_chan_sel.
module adc_frame_ctrl #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned NUM_CH        = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [2:0] i_chan_sel,
  output logic       o_adc_cs_n,
  output logic       o_adc_sclk,
  output logic       o_adc_din,
  output logic       o_sclk_rise,
  output logic       o_frame_active,
  output logic       o_frame_done,
  output logic [2:0] o_cur_chan,
  output logic [2:0] o_data_chan
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TmrW = $clog2(SAMPLE_PERIOD);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);
  localparam logic [TmrW-1:0] TmrMax = TmrW'(SAMPLE_PERIOD - 1);

  if (CLK_DIV < 1 || SAMPLE_PERIOD < 36 * CLK_DIV || NUM_CH < 1 || NUM_CH > 8) begin : g_bad_cfg
    $error("adc_frame_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e          r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]      r_half, w_half_nxt;
  logic [TmrW-1:0] r_timer, w_timer_nxt;
  logic            r_cs_n, w_cs_n_nxt;
  logic            r_sclk, w_sclk_nxt;
  logic            r_din, w_din_nxt;
  logic            r_sclk_rise, w_sclk_rise_nxt;
  logic            r_frame_done, w_frame_done_nxt;
  logic [2:0]      r_cur_chan, w_cur_chan_nxt;
  logic [2:0]      r_data_chan, w_data_chan_nxt;
  logic            w_tick;
  logic            w_lvl_end;
  logic [2:0]      w_new_chan;

`ifdef ADC_SCAN_EN
  localparam logic [2:0] ScanLast = 3'(NUM_CH - 1);
  logic [2:0] r_scan_idx, w_scan_idx_nxt;
  assign w_new_chan = r_scan_idx;
`else
  assign w_new_chan = i_chan_sel;
`endif

  // Frame bit k as shifted on falling edge k; address sits in bits 2..4, MSB first.
  function automatic logic frame_bit(input logic [3:0] k, input logic [2:0] ch);
    unique case (k)
      4'd2:    frame_bit = ch[2];
      4'd3:    frame_bit = ch[1];
      4'd4:    frame_bit = ch[0];
      default: frame_bit = 1'b0;
    endcase
  endfunction

  assign w_tick      = (r_timer == TmrMax);
  assign w_lvl_end   = (r_cnt == CntMax);
  assign w_timer_nxt = w_tick ? '0 : r_timer + TmrW'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_half_nxt       = r_half;
    w_cs_n_nxt       = r_cs_n;
    w_sclk_nxt       = r_sclk;
    w_din_nxt        = r_din;
    w_sclk_rise_nxt  = 1'b0;
    w_frame_done_nxt = 1'b0;
    w_cur_chan_nxt   = r_cur_chan;
    w_data_chan_nxt  = r_data_chan;
`ifdef ADC_SCAN_EN
    w_scan_idx_nxt   = r_scan_idx;
`endif
    unique case (r_state)
      StIdle: begin
        w_cs_n_nxt = 1'b1;
        w_sclk_nxt = 1'b1;
        if (w_tick && i_enable) begin
          w_state_nxt     = StSetup;
          w_cs_n_nxt      = 1'b0;
          w_cnt_nxt       = '0;
          w_data_chan_nxt = r_cur_chan;
          w_cur_chan_nxt  = w_new_chan;
`ifdef ADC_SCAN_EN
          w_scan_idx_nxt  = (r_scan_idx == ScanLast) ? 3'd0 : r_scan_idx + 3'd1;
`endif
        end
      end
      StSetup: begin
        w_cnt_nxt = r_cnt + CntW'(1);
        if (w_lvl_end) begin
          w_state_nxt = StShift;
          w_cnt_nxt   = '0;
          w_half_nxt  = '0;
          w_sclk_nxt  = 1'b0;
          w_din_nxt   = frame_bit(4'd0, r_cur_chan);
        end
      end
      StShift: begin
        w_cnt_nxt = r_cnt + CntW'(1);
        if (w_lvl_end) begin
          w_cnt_nxt  = '0;
          w_half_nxt = r_half + 5'd1;
          if (!r_half[0]) begin
            w_sclk_nxt      = 1'b1;
            w_sclk_rise_nxt = 1'b1;
          end else if (r_half == 5'd31) begin
            w_state_nxt = StHold;
          end else begin
            w_sclk_nxt = 1'b0;
            w_din_nxt  = frame_bit(r_half[4:1] + 4'd1, r_cur_chan);
          end
        end
      end
      StHold: begin
        w_cnt_nxt = r_cnt + CntW'(1);
        if (w_lvl_end) begin
          w_state_nxt      = StIdle;
          w_cnt_nxt        = '0;
          w_cs_n_nxt       = 1'b1;
          w_din_nxt        = 1'b0;
          w_frame_done_nxt = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_half       <= '0;
      r_timer      <= '0;
      r_cs_n       <= 1'b1;
      r_sclk       <= 1'b1;
      r_din        <= 1'b0;
      r_sclk_rise  <= 1'b0;
      r_frame_done <= 1'b0;
      r_cur_chan   <= '0;
      r_data_chan  <= '0;
`ifdef ADC_SCAN_EN
      r_scan_idx   <= '0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_half       <= w_half_nxt;
      r_timer      <= w_timer_nxt;
      r_cs_n       <= w_cs_n_nxt;
      r_sclk       <= w_sclk_nxt;
      r_din        <= w_din_nxt;
      r_sclk_rise  <= w_sclk_rise_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_cur_chan   <= w_cur_chan_nxt;
      r_data_chan  <= w_data_chan_nxt;
`ifdef ADC_SCAN_EN
      r_scan_idx   <= w_scan_idx_nxt;
`endif
    end
  end

  assign o_adc_cs_n     = r_cs_n;
  assign o_adc_sclk     = r_sclk;
  assign o_adc_din      = r_din;
  assign o_sclk_rise    = r_sclk_rise;
  assign o_frame_active = ~r_cs_n;
  assign o_frame_done   = r_frame_done;
  assign o_cur_chan     = r_cur_chan;
  assign o_data_chan    = r_data_chan;

endmodule

// File: tb/tb_adc_frame_ctrl.sv
// Directed self-checking bench for adc_frame_ctrl (CLK_DIV=2, SAMPLE_PERIOD=100).
module tb_adc_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [2:0] chan_sel;
  logic       adc_cs_n, adc_sclk, adc_din, sclk_rise, frame_active, frame_done;
  logic [2:0] cur_chan, data_chan;

  adc_frame_ctrl #(
    .CLK_DIV       (2),
    .SAMPLE_PERIOD (100),
    .NUM_CH        (3)
  ) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (enable),
    .i_chan_sel     (chan_sel),
    .o_adc_cs_n     (adc_cs_n),
    .o_adc_sclk     (adc_sclk),
    .o_adc_din      (adc_din),
    .o_sclk_rise    (sclk_rise),
    .o_frame_active (frame_active),
    .o_frame_done   (frame_done),
    .o_cur_chan     (cur_chan),
    .o_data_chan    (data_chan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [15:0] exp_bits(input logic [2:0] ch);
    logic [15:0] b;
    b = '0;
    b[2] = ch[2];
    b[3] = ch[1];
    b[4] = ch[0];
    return b;
  endfunction

  // Frame monitor, sampled 1 time unit after each rising edge.
  int          cyc = 0;
  int          low_cnt = 0, rise_cnt = 0, n_frames = 0, done_total = 0;
  int          start_cyc = 0, prev_start_cyc = 0;
  logic [15:0] bits = '0;
  int          f_low = 0, f_rises = 0;
  logic [15:0] f_bits = '0;
  logic        prev_cs_n = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_cs_n && !adc_cs_n) begin
      prev_start_cyc = start_cyc;
      start_cyc      = cyc;
      low_cnt        = 0;
      rise_cnt       = 0;
      bits           = '0;
      n_frames++;
    end
    if (!adc_cs_n) low_cnt++;
    if (sclk_rise) begin
      if (rise_cnt < 16) bits[rise_cnt] = adc_din;
      rise_cnt++;
    end
    if (frame_done) begin
      done_total++;
      f_low   = low_cnt;
      f_rises = rise_cnt;
      f_bits  = bits;
    end
    prev_cs_n = adc_cs_n;
  end

  task automatic wait_start(input string tag, input int budget);
    int n0 = n_frames;
    int i  = 0;
    while (n_frames == n0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, 32'(n_frames != n0), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0 = done_total;
    int i  = 0;
    while (done_total == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, 32'(done_total != d0), 32'd1);
  endtask

  task automatic wait_rises(input string tag, input int n, input int budget);
    int i = 0;
    while (rise_cnt < n && i < budget) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, 32'(rise_cnt >= n), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [2:0] ch, input logic [2:0] dch);
    check_eq({tag, "_low"}, 32'(f_low), 32'd68);
    check_eq({tag, "_rises"}, 32'(f_rises), 32'd16);
    check_eq({tag, "_bits"}, 32'(f_bits), 32'(exp_bits(ch)));
    check_eq({tag, "_cur"}, 32'(cur_chan), 32'(ch));
    check_eq({tag, "_data"}, 32'(data_chan), 32'(dch));
  endtask

  initial begin
    int d0, nf;
    rst_n    = 1'b0;
    enable   = 1'b0;
    chan_sel = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check_eq("rst_sclk", 32'(adc_sclk), 32'd1);
    check_eq("rst_din", 32'(adc_din), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    check_eq("rst_active", 32'(frame_active), 32'd0);
    check_eq("rst_rise", 32'(sclk_rise), 32'd0);
    check_eq("rst_cur", 32'(cur_chan), 32'd0);
    check_eq("rst_data", 32'(data_chan), 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
`ifdef ADC_SCAN_EN
    chan_sel = 3'd7;
    begin
      logic [2:0] exp_cur [5] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};
      logic [2:0] exp_dat [5] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0};
      for (int f = 0; f < 5; f++) begin
        wait_done($sformatf("scan%0d_timeout", f), 300);
        check_frame($sformatf("scan%0d", f), exp_cur[f], exp_dat[f]);
      end
    end
`else
    chan_sel = 3'd5;
    // Frame 1: chan 5, chan_sel changes mid-frame
    wait_start("f1_start_timeout", 300);
    check_eq("f1_active", 32'(frame_active), 32'd1);
    repeat (10) @(negedge clk);
    chan_sel = 3'd2;
    d0 = done_total;
    wait_done("f1_done_timeout", 200);
    check_frame("f1", 3'd5, 3'd0);
    repeat (3) @(negedge clk);
    check_eq("f1_done_once", 32'(done_total - d0), 32'd1);
    check_eq("idle_sclk", 32'(adc_sclk), 32'd1);
    check_eq("idle_din", 32'(adc_din), 32'd0);
    // Frame 2: chan 2, previous address now reported as data channel
    wait_start("f2_start_timeout", 200);
    check_eq("f2_period", 32'(start_cyc - prev_start_cyc), 32'd100);
    wait_done("f2_done_timeout", 200);
    check_frame("f2", 3'd2, 3'd5);
    // Frame 3: enable dropped at the 8th rising edge
    chan_sel = 3'd3;
    wait_start("f3_start_timeout", 200);
    wait_rises("f3_rise8_timeout", 8, 200);
    enable = 1'b0;
    wait_done("f3_done_timeout", 200);
    check_frame("f3", 3'd3, 3'd2);
    nf = n_frames;
    repeat (250) @(negedge clk);
    check_eq("no_frame_when_disabled", 32'(n_frames), 32'(nf));
    check_eq("disabled_cs_n", 32'(adc_cs_n), 32'd1);
    // Frame 4: reset asserted at the 8th rising edge
    enable   = 1'b1;
    chan_sel = 3'd6;
    wait_start("f4_start_timeout", 200);
    wait_rises("f4_rise8_timeout", 8, 200);
    d0    = done_total;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_cs_n", 32'(adc_cs_n), 32'd1);
    check_eq("midrst_sclk", 32'(adc_sclk), 32'd1);
    check_eq("midrst_din", 32'(adc_din), 32'd0);
    check_eq("midrst_cur", 32'(cur_chan), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_no_done", 32'(done_total), 32'(d0));
    // Frame 5: clean frame after reset, data channel back to 0
    wait_start("f5_start_timeout", 300);
    wait_done("f5_done_timeout", 200);
    check_frame("f5", 3'd6, 3'd0);
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
